// File: rtl/ttl_univ_shift_sync_pkg.sv
// Shared definitions for the 74194-style shift parts: mode encodings and the
// counter-width helper also used by the other shift and counter blocks.
package ttl_univ_shift_sync_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_e;

  // Bits needed to count 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ttl_univ_shift_sync_if.sv
// Data/control bundle for ttl_univ_shift_sync. Done exists only when
// TTL_SHIFT_DONE_EN is defined.
interface ttl_univ_shift_sync_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       S;
  logic             DSR;
  logic             DSL;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
`ifdef TTL_SHIFT_DONE_EN
  logic             Done;

  modport master (output S, DSR, DSL, D, input Q, Done);
  modport slave  (input S, DSR, DSL, D, output Q, Done);
`else
  modport master (output S, DSR, DSL, D, input Q);
  modport slave  (input S, DSR, DSL, D, output Q);
`endif
endinterface

// File: rtl/ttl_univ_shift_cell.sv
// One bit of the universal shift register: 4:1 mode mux feeding a flop.
// Any unrecognised mode (including X in simulation) holds the bit.
module ttl_univ_shift_cell
  import ttl_univ_shift_sync_pkg::*;
(
  input  logic       clk,
  input  logic [1:0] mode,
  input  logic       shr_in,
  input  logic       shl_in,
  input  logic       load_in,
  output logic       q
);

  always_ff @(posedge clk) begin
    case (mode)
      MODE_SHR:  q <= shr_in;
      MODE_SHL:  q <= shl_in;
      MODE_LOAD: q <= load_in;
      default:   q <= q;
    endcase
  end

endmodule

// File: rtl/ttl_univ_shift_sync.sv
// 74194-style universal shift register with synchronous active-high Clear.
// Optional shift counter and Done flag under macro TTL_SHIFT_DONE_EN.
module ttl_univ_shift_sync
  import ttl_univ_shift_sync_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                  Clk,
  input  logic                  Clear,
  ttl_univ_shift_sync_if.slave  bus
);

  // Output delays describe the part for behavioural models only; the
  // synthesizable register has none, so only sanity-check the values here.
  if (WIDTH < 2) begin : g_bad_width
    $error("ttl_univ_shift_sync: WIDTH must be at least 2");
  end
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("ttl_univ_shift_sync: delays must be non-negative");
  end

  logic [1:0]       mode_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH-1:0] q_int;

  // Clear is folded into a load of zero so each cell stays a plain 4:1 mux.
  assign mode_eff = Clear ? MODE_LOAD : bus.S;
  assign load_eff = Clear ? '0 : bus.D;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shr_in;
    logic shl_in;

    if (i == 0) begin : g_lsb
      assign shr_in = bus.DSR;
    end else begin : g_shr
      assign shr_in = q_int[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign shl_in = bus.DSL;
    end else begin : g_shl
      assign shl_in = q_int[i+1];
    end

    ttl_univ_shift_cell u_cell (
      .clk     (Clk),
      .mode    (mode_eff),
      .shr_in  (shr_in),
      .shl_in  (shl_in),
      .load_in (load_eff[i]),
      .q       (q_int[i])
    );
  end

  assign bus.Q = q_int;

`ifdef TTL_SHIFT_DONE_EN
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          done_q;

  always_comb begin
    cnt_nxt = cnt;
    if (Clear) begin
      cnt_nxt = '0;
    end else begin
      case (bus.S)
        MODE_LOAD: cnt_nxt = '0;
        MODE_SHR,
        MODE_SHL: begin
          if (cnt != CW'(WIDTH)) cnt_nxt = cnt + CW'(1);
        end
        default: cnt_nxt = cnt;
      endcase
    end
  end

  // Done is registered from the next count so it rises with the WIDTH-th shift.
  always_ff @(posedge Clk) begin
    cnt    <= cnt_nxt;
    done_q <= (cnt_nxt == CW'(WIDTH));
  end

  assign bus.Done = done_q;
`endif

endmodule

// File: tb/tb_ttl_univ_shift_sync.sv
// Directed plus randomized checks of ttl_univ_shift_sync against a value-level
// model; Done checks are active when TTL_SHIFT_DONE_EN is defined.
module tb_ttl_univ_shift_sync;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clear;

  always #5 clk = ~clk;

  ttl_univ_shift_sync_if #(.WIDTH(W)) bus ();

  ttl_univ_shift_sync #(
    .WIDTH      (W),
    .DELAY_RISE (0),
    .DELAY_FALL (0)
  ) dut (
    .Clk   (clk),
    .Clear (clear),
    .bus   (bus)
  );

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] m_q;
  int           m_shifts;

  task automatic check_model(input string tag);
    n_cmp++;
    assert (bus.Q === m_q) else begin
      n_fail++;
      $error("FAIL %s: Q=%h expected %h", tag, bus.Q, m_q);
    end
`ifdef TTL_SHIFT_DONE_EN
    n_cmp++;
    assert (bus.Done === (m_shifts >= W)) else begin
      n_fail++;
      $error("FAIL %s_done: Done=%b expected %b", tag, bus.Done, (m_shifts >= W));
    end
`endif
  endtask

  task automatic step(input string tag, input logic c, input logic [1:0] s,
                      input logic dsr, input logic dsl, input logic [W-1:0] d);
    @(negedge clk);
    clear   = c;
    bus.S   = s;
    bus.DSR = dsr;
    bus.DSL = dsl;
    bus.D   = d;
    @(posedge clk);
    if (c) begin
      m_q = '0;
      m_shifts = 0;
    end else if (s === 2'b11) begin
      m_q = d;
      m_shifts = 0;
    end else if (s === 2'b01) begin
      m_q = W'(int'(m_q) * 2 + int'(dsr));
      m_shifts++;
    end else if (s === 2'b10) begin
      m_q = W'(int'(m_q) / 2 + (dsl ? (2 ** (W - 1)) : 0));
      m_shifts++;
    end
    #1;
    check_model(tag);
  endtask

  task automatic expect_q(input string tag, input logic [W-1:0] exp);
    n_cmp++;
    assert (bus.Q === exp) else begin
      n_fail++;
      $error("FAIL %s: Q=%h expected %h", tag, bus.Q, exp);
    end
  endtask

  task automatic expect_y(input string tag, input logic [1:0] exp);
    logic [1:0] y;
    y = {&bus.Q[7:4], &bus.Q[3:0]};
    n_cmp++;
    assert (y === exp) else begin
      n_fail++;
      $error("FAIL %s: Y=%b expected %b", tag, y, exp);
    end
  endtask

`ifdef TTL_SHIFT_DONE_EN
  task automatic expect_done(input string tag, input logic exp);
    n_cmp++;
    assert (bus.Done === exp) else begin
      n_fail++;
      $error("FAIL %s: Done=%b expected %b", tag, bus.Done, exp);
    end
  endtask
`endif

  initial begin
    logic       rc;
    logic [1:0] rs;
    clear = 1'b0; bus.S = 2'b00; bus.DSR = 1'b0; bus.DSL = 1'b0; bus.D = '0;
    m_q = 'x; m_shifts = 0;

    // Reset and hold
    step("clear", 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    expect_q("clear_q", 8'h00);
`ifdef TTL_SHIFT_DONE_EN
    expect_done("clear_done", 1'b0);
`endif
    for (int i = 0; i < 3; i++) step("hold0", 1'b0, 2'b00, 1'b1, 1'b1, 8'hFF);
    expect_q("hold0_q", 8'h00);

    // Parallel load then hold
    step("load_a5", 1'b0, 2'b11, 1'b0, 1'b0, 8'hA5);
    expect_q("load_a5_q", 8'hA5);
    step("hold_a5", 1'b0, 2'b00, 1'b1, 1'b1, 8'h00);
    step("hold_a5", 1'b0, 2'b00, 1'b0, 1'b1, 8'h5A);
    expect_q("hold_a5_q", 8'hA5);

    // Shift right fill with ones, downstream AND decode
    step("load_00", 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
    step("shr1", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    expect_q("shr1_q", 8'h01);
    step("shr2", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    expect_q("shr2_q", 8'h03);
    step("shr3", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    expect_q("shr3_q", 8'h07);
    step("shr4", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    expect_q("shr4_q", 8'h0F);
    expect_y("shr4_y", 2'b01);
    for (int i = 0; i < 4; i++) step("shr_more", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    expect_q("shr8_q", 8'hFF);
    expect_y("shr8_y", 2'b11);

    // Shift left drops bit 0, shift right brings it back
    step("load_81", 1'b0, 2'b11, 1'b0, 1'b1, 8'h81);
    step("shl1", 1'b0, 2'b10, 1'b1, 1'b0, 8'h00);
    expect_q("shl1_q", 8'h40);
    step("shr_back", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    expect_q("shr_back_q", 8'h81);

    // Clear wins over a shift on the same edge
    step("load_ff", 1'b0, 2'b11, 1'b0, 1'b0, 8'hFF);
    step("clr_shift", 1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
    expect_q("clr_shift_q", 8'h00);
    step("load_3c", 1'b0, 2'b11, 1'b0, 1'b0, 8'h3C);
    expect_q("load_3c_q", 8'h3C);

    // Unknown mode behaves as hold
    step("s_x", 1'b0, 2'bxx, 1'b1, 1'b1, 8'hFF);
    expect_q("s_x_q", 8'h3C);

`ifdef TTL_SHIFT_DONE_EN
    step("dn_load", 1'b0, 2'b11, 1'b0, 1'b0, 8'h12);
    for (int i = 0; i < 7; i++) step("dn_shift", 1'b0, (i % 2) ? 2'b10 : 2'b01, 1'b1, 1'b0, 8'h00);
    expect_done("dn_7", 1'b0);
    step("dn_8", 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
    expect_done("dn_8", 1'b1);
    step("dn_9", 1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
    expect_done("dn_9", 1'b1);
    step("dn_hold", 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    expect_done("dn_hold", 1'b1);
    step("dn_reload", 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
    expect_done("dn_reload", 1'b0);
    for (int i = 0; i < 7; i++) step("dn_shift2", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    step("dn_clr_sat", 1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    expect_done("dn_clr_sat", 1'b0);
`endif

    // Randomized mix of modes, clears and unknown selects
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 15) == 0);
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) rs = 2'bxx;
      step("rand", rc, rs, 1'($urandom), 1'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
